// File: rtl/m_spram_pkg.sv
// Shared types and constants for the Wishbone SPRAM slave.
package m_spram_pkg;

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_RD    = 3'd1,
    ST_RD2   = 3'd2,
    ST_STBY  = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  localparam int unsigned SP_AW      = 14;
  localparam int unsigned PAIR_BYTES = 65536;
  localparam logic [31:0] DAT_FILL   = 32'habbababa;

  // Each byte enable covers two 4-bit MASKWREN lanes.
  function automatic logic [7:0] sel_to_mask(input logic [3:0] sel);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[2*b +: 2] = {2{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/m_spram_pair.sv
// One 16K x 32 bank with the SB_SPRAM256KA interface: two 16-bit halves.
module m_spram_pair
  import m_spram_pkg::*;
(
  input  logic             CLK_I,
  input  logic [SP_AW-1:0] adr,
  input  logic [31:0]      dat,
  input  logic [7:0]       mask,
  input  logic             wren,
  input  logic             standby,
  output logic [31:0]      rdata
);

  localparam int unsigned DEPTH = 2 ** SP_AW;

  logic [15:0] mem_lo [DEPTH];
  logic [15:0] mem_hi [DEPTH];

  // Nibble-masked write, synchronous read, frozen while in standby.
  always_ff @(posedge CLK_I) begin
    if (!standby) begin
      if (wren) begin
        for (int n = 0; n < 4; n++) begin
          if (mask[n])     mem_lo[adr][4*n +: 4] <= dat[4*n +: 4];
          if (mask[n + 4]) mem_hi[adr][4*n +: 4] <= dat[16 + 4*n +: 4];
        end
      end else begin
        rdata <= {mem_hi[adr], mem_lo[adr]};
      end
    end
  end

endmodule

// File: rtl/m_spram_wb.sv
// Wishbone-classic slave RAM on iCE40UP SPRAM with configurable size,
// read latency and idle-driven standby.
module m_spram_wb
  import m_spram_pkg::*;
#(
  parameter int unsigned NPAIRS   = 2,
  parameter int unsigned RDLAT    = 1,
  parameter int unsigned IDLESTBY = 0,
  parameter int unsigned WAKECYC  = 3,
  localparam int unsigned ADRW    = 15 + NPAIRS
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [31:0]     DAT_I,
  input  logic [ADRW-1:0] ADR_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [3:0]      SEL_I,
  output logic [31:0]     DAT_O,
  output logic            ACK_O,
  output logic            STBY_O
);

  localparam logic [7:0] IDLE_MAX  = 8'(IDLESTBY);
  localparam logic [2:0] WAKE_LAST = 3'(WAKECYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        idle_q, idle_d;
  logic [2:0]        wake_q, wake_d;
  logic [31:0]       rdreg_q, rdreg_d;
  logic              standby_q;
  logic              stby_q;
  logic              ack_c;
  logic [31:0]       dat_c;
  logic              wr_req;
  logic              psel;
  logic [31:0]       rd_mux;
  logic [7:0]        mask;
  logic [NPAIRS-1:0] wren;
  logic [31:0]       pair_q [NPAIRS];
  logic              adr_unused;

  assign adr_unused = ^ADR_I[1:0];
  assign mask       = sel_to_mask(SEL_I);

  // Pair select comes straight from the bus address, which is held until ACK.
  if (NPAIRS == 2) begin : g_two
    assign psel   = ADR_I[ADRW-1];
    assign rd_mux = psel ? pair_q[1] : pair_q[0];
  end else begin : g_one
    assign psel   = 1'b0;
    assign rd_mux = pair_q[0];
  end

  for (genvar p = 0; p < NPAIRS; p++) begin : g_pair
    m_spram_pair u_pair (
      .CLK_I   (CLK_I),
      .adr     (ADR_I[SP_AW+1:2]),
      .dat     (DAT_I),
      .mask    (mask),
      .wren    (wren[p]),
      .standby (standby_q),
      .rdata   (pair_q[p])
    );
  end

  assign wr_req = (state_q == ST_READY) && STB_I && WE_I && !RST_I;

  always_comb begin
    wren = '0;
    for (int p = 0; p < NPAIRS; p++) wren[p] = wr_req && (int'(psel) == p);
  end

  // Next state, counters and the combinational bus response.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = '0;
    rdreg_d = rdreg_q;
    ack_c   = 1'b0;
    dat_c   = DAT_FILL;
    case (state_q)
      ST_READY: begin
        if (STB_I) begin
          idle_d = '0;
          if (WE_I) ack_c   = 1'b1;
          else      state_d = ST_RD;
        end else if (IDLESTBY != 0) begin
          if (idle_q != IDLE_MAX) idle_d = 8'(idle_q + 8'd1);
          if (idle_d == IDLE_MAX) state_d = ST_STBY;
        end
      end
      ST_RD: begin
        if (RDLAT == 2) begin
          rdreg_d = rd_mux;
          state_d = ST_RD2;
        end else begin
          ack_c   = 1'b1;
          dat_c   = rd_mux;
          state_d = ST_READY;
        end
      end
      ST_RD2: begin
        ack_c   = 1'b1;
        dat_c   = rdreg_q;
        state_d = ST_READY;
      end
      ST_STBY: begin
        if (STB_I) begin
          idle_d  = '0;
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        idle_d = '0;
        if (wake_q == WAKE_LAST) state_d = ST_READY;
        else                     wake_d  = 3'(wake_q + 3'd1);
      end
      default: state_d = ST_READY;
    endcase
    // A reset landing mid-access must not acknowledge it.
    if (RST_I) begin
      ack_c = 1'b0;
      dat_c = DAT_FILL;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= ST_READY;
      idle_q    <= '0;
      wake_q    <= '0;
      rdreg_q   <= '0;
      standby_q <= 1'b0;
      stby_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      wake_q    <= wake_d;
      rdreg_q   <= rdreg_d;
      standby_q <= (state_d == ST_STBY);
      stby_q    <= (state_d == ST_STBY) || (state_d == ST_WAKE);
    end
  end

  assign ACK_O  = ack_c;
  assign DAT_O  = dat_c;
  assign STBY_O = stby_q;

endmodule

// File: tb/tb_m_spram_wb.sv
// Directed bench for m_spram_wb: one 128 KiB / 1-cycle instance and one
// 64 KiB / 2-cycle instance with standby enabled.
module tb_m_spram_wb;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] dat_i [2];
  logic [16:0] adr   [2];
  logic [31:0] dat_o [2];
  logic        ack   [2];
  logic        stby  [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [int];

  always #5 clk = ~clk;

  m_spram_wb #(.NPAIRS(2), .RDLAT(1), .IDLESTBY(0), .WAKECYC(3)) u_a (
    .CLK_I (clk), .RST_I (rst[0]), .DAT_I (dat_i[0]), .ADR_I (adr[0]),
    .STB_I (stb[0]), .WE_I (we[0]), .SEL_I (sel[0]),
    .DAT_O (dat_o[0]), .ACK_O (ack[0]), .STBY_O (stby[0])
  );

  m_spram_wb #(.NPAIRS(1), .RDLAT(2), .IDLESTBY(4), .WAKECYC(3)) u_b (
    .CLK_I (clk), .RST_I (rst[1]), .DAT_I (dat_i[1]), .ADR_I (adr[1][15:0]),
    .STB_I (stb[1]), .WE_I (we[1]), .SEL_I (sel[1]),
    .DAT_O (dat_o[1]), .ACK_O (ack[1]), .STBY_O (stby[1])
  );

  function automatic int mkey(input int d, input logic [16:0] a);
    return d * (1 << 20) + int'(a[16:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one access (STB may already be high) and wait for its ACK.
  task automatic access(input int d, input logic w, input logic [16:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        input int exp_lat, input string tag);
    int          lat;
    int          k;
    logic [31:0] cur;
    logic [31:0] expv;
    k = mkey(d, a);
    stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_i[d] = wd; sel[d] = s;
    if (w) begin
      cur = model.exists(k) ? model[k] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = wd[8*b +: 8];
      model[k] = cur;
    end else begin
      exp_q.push_back(model.exists(k) ? model[k] : 32'h0);
    end
    lat = 0;
    @(negedge clk);
    while (!ack[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    chk({tag, "_ack"}, 32'(ack[d]), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!w) begin
      expv = exp_q.pop_front();
      chk({tag, "_dat"}, dat_o[d], expv);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    stb[d] = 1'b0; we[d] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int          hit;
    logic [31:0] expv;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = 4'h0; dat_i[d] = 32'h0; adr[d] = 17'h0;
    end
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0;

    // Instance A: NPAIRS=2, RDLAT=1, no standby.
    @(negedge clk);
    chk("a_rst_ack", 32'(ack[0]), 32'd0);
    chk("a_rst_stby", 32'(stby[0]), 32'd0);
    chk("a_fill", dat_o[0], 32'habbababa);
    @(posedge clk); #1;

    access(0, 1'b1, 17'h00010, 32'hDEADBEEF, 4'hF, 0, "a_wr10");
    access(0, 1'b1, 17'h10010, 32'hCAFEF00D, 4'hF, 0, "a_wr10010");
    access(0, 1'b1, 17'h00020, 32'h11223344, 4'hF, 0, "a_wr20");
    access(0, 1'b1, 17'h00020, 32'hAABBCCDD, 4'b0101, 0, "a_wrbyte");
    access(0, 1'b1, 17'h00030, 32'h55667788, 4'hF, 0, "a_wr30");
    access(0, 1'b1, 17'h00030, 32'hFFFFFFFF, 4'h0, 0, "a_wrsel0");
    access(0, 1'b0, 17'h00010, 32'h0, 4'hF, 1, "a_rd10");
    access(0, 1'b0, 17'h10010, 32'h0, 4'hF, 1, "a_rd10010");
    access(0, 1'b0, 17'h00020, 32'h0, 4'hF, 1, "a_rdbyte");
    access(0, 1'b0, 17'h00030, 32'h0, 4'hF, 1, "a_rdsel0");
    idle(0, 1);

    // Reset while the read sits in RD.
    stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 17'h00010; sel[0] = 4'hF;
    @(negedge clk);
    chk("a_rrd_req_ack", 32'(ack[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b1; stb[0] = 1'b0;
    @(negedge clk);
    chk("a_rrd_ack", 32'(ack[0]), 32'd0);
    chk("a_rrd_stby", 32'(stby[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("a_rrd_post_ack", 32'(ack[0]), 32'd0);
    @(posedge clk); #1;
    access(0, 1'b0, 17'h00010, 32'h0, 4'hF, 1, "a_rrd_again");
    idle(0, 1);

    // Instance B: NPAIRS=1, RDLAT=2, IDLESTBY=4, WAKECYC=3.
    rst[1] = 1'b0;
    @(negedge clk);
    chk("b_rst_ack", 32'(ack[1]), 32'd0);
    chk("b_rst_stby", 32'(stby[1]), 32'd0);
    @(posedge clk); #1;

    access(1, 1'b1, 17'h0FFFC, 32'h0BADC0DE, 4'hF, 0, "b_wrfffc");
    access(1, 1'b1, 17'h00004, 32'h44444444, 4'hF, 0, "b_wr4");
    access(1, 1'b1, 17'h00008, 32'h88888888, 4'hF, 0, "b_wr8");
    access(1, 1'b0, 17'h0FFFC, 32'h0, 4'hF, 2, "b_rdfffc");
    access(1, 1'b0, 17'h00004, 32'h0, 4'hF, 2, "b_b2b_4");
    access(1, 1'b0, 17'h00008, 32'h0, 4'hF, 2, "b_b2b_8");

    // Four idle cycles, then standby.
    stb[1] = 1'b0; we[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("b_idle_stby", 32'(stby[1]), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("b_stby_on", 32'(stby[1]), 32'd1);
    chk("b_stby_ack", 32'(ack[1]), 32'd0);
    @(posedge clk); #1;

    // Read from standby: 3 wake cycles, then the normal 2-cycle read.
    stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 17'h00004; sel[1] = 4'hF;
    exp_q.push_back(model[mkey(1, 17'h00004)]);
    hit = -1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      chk("b_wake_stby", 32'(stby[1]), (i <= 3) ? 32'd1 : 32'd0);
      if (ack[1] && hit < 0) hit = i;
      if (i < 6) begin @(posedge clk); #1; end
    end
    chk("b_wake_rd_lat", 32'(hit), 32'd6);
    expv = exp_q.pop_front();
    chk("b_wake_rd_dat", dat_o[1], expv);
    @(posedge clk); #1;

    // Write from standby: ACK after WAKECYC+1 cycles.
    idle(1, 5);
    access(1, 1'b1, 17'h00008, 32'h12345678, 4'b0011, 4, "b_wake_wr");
    access(1, 1'b0, 17'h00008, 32'h0, 4'hF, 2, "b_rd_after");
    idle(1, 1);
    @(negedge clk);
    chk("b_final_stby", 32'(stby[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/m_spram_wb.md
Name: m_spram_wb

Overview:
- Wishbone-classic slave RAM built from iCE40UP SB_SPRAM256KA macros; successor to the fixed 128 KiB RAM block.
- Parametrised in bank-pair count (64 KiB or 128 KiB) and read latency (1 or 2 cycles).
- Adds idle-driven SPRAM standby with a timed wake-up.
- Sits between the midgetv core bus and on-chip SPRAM.

Parameters:
- NPAIRS, 2, number of SPRAM pairs (1 or 2); each pair is 16K x 32 bit (64 KiB). ADRW = 15 + NPAIRS (16 or 17).
- RDLAT, 1, read latency (1 or 2). 2 adds a registered DAT_O stage.
- IDLESTBY, 0, idle cycles before standby; 0 disables standby (1..255 otherwise).
- WAKECYC, 3, cycles STANDBY is held low before the first access after wake (1..7).

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset, synchronous, active-high
- DAT_I  in  32  write data
- ADR_I  in  ADRW  byte address; bits [1:0] ignored, [15:2] word address, [16] pair select when NPAIRS=2
- STB_I  in  1  access request; held until ACK_O
- WE_I  in  1  1 = write
- SEL_I  in  4  byte enables
- DAT_O  out  32  read data, valid only while ACK_O=1
- ACK_O  out  1  access acknowledge
- STBY_O  out  1  1 while SPRAMs are in standby or waking

Behaviour:
- Reset: state READY, idle counter 0, wake counter 0, ACK_O=0, STBY_O=0, SPRAM STANDBY=0, RDLAT=2 output register 0. Reset during a read aborts it; no ACK is issued.
- SPRAM tie-offs: CHIPSELECT=1, POWEROFF=1 (active-low), SLEEP=0.
- Byte masks: each SEL_I[b] drives two MASKWREN bits of the 16-bit SPRAM covering byte b.
- FSM states: READY, RD, RD2, STBY, WAKE.
- READY, write (STB_I & WE_I):
  - WREN asserted this cycle on the pair selected by ADR_I[16] (pair 0 if NPAIRS=1).
  - ACK_O is combinational in the same cycle; state stays READY.
  - SEL_I=0 still acks; no byte changes.
- READY, read (STB_I & ~WE_I):
  - No ACK this cycle; go to RD.
  - RDLAT=1: RD drives ACK_O=1 with DAT_O = SPRAM output muxed by ADR_I[16], then returns to READY.
  - RDLAT=2: RD captures the muxed data into the output register and goes to RD2. RD2 drives ACK_O=1 from the register, then returns to READY.
- A STB_I still high in the ACK cycle belongs to the acknowledged access. STB_I high in the following READY cycle is a new request, so a read never produces a double ACK.
- ADR_I is stable until ACK_O. Pair select is taken from ADR_I directly; it is not pipelined.
- Idle counter:
  - In READY with STB_I=0, it increments, saturating at IDLESTBY. Any STB_I=1 clears it.
  - When IDLESTBY != 0 and the count reaches IDLESTBY, go to STBY. STANDBY=1 and STBY_O=1 from the next cycle.
- STBY: no ACK and no WREN. STB_I=1 moves to WAKE. STANDBY drops to 0 in the first WAKE cycle; STBY_O stays 1.
- WAKE: the wake counter counts WAKECYC cycles, then the FSM returns to READY with STBY_O=0. The pending request is then served as a normal READY request.
  - Write wake-to-ack = WAKECYC + 1 cycles after STB_I rises in STBY.
  - Read wake-to-ack = WAKECYC + 1 + RDLAT.
- If STB_I drops during WAKE, the wake still completes and the FSM returns to READY.
- IDLESTBY=0: STBY and WAKE are unreachable; STBY_O is constant 0.
- DAT_O when ACK_O=0: don't-care. Under verilator it is 32'habbababa.

Decomposition:
- Package m_spram_pkg: FSM state encoding, SPRAM word-address width (14), pair size constant, verilator fill pattern 32'habbababa.
- Sub-module m_spram_pair: two SB_SPRAM256KA forming one 32-bit, 16K-word bank. Inputs: address, data, 8-bit mask, wren, standby. Output: 32-bit data. Instantiated NPAIRS times via generate.

Test Plan:
- Write then read, NPAIRS=2, RDLAT=1: write 32'hDEADBEEF at 0x00010, SEL=4'hF, ACK in the same cycle. Read 0x00010: ACK one cycle after STB, DAT_O=32'hDEADBEEF. Read 0x10010 returns pair-1 contents, not DEADBEEF.
- Byte write: with 0x00020 preloaded to 32'h11223344, write 32'hAABBCCDD with SEL=4'b0101 -> read returns 32'h11BB33DD.
- RDLAT=2 back-to-back reads: STB held across reads of 0x4 then 0x8 -> each ACK is exactly one cycle wide, two cycles after its request. No extra ACK and no stale data.
- Standby, IDLESTBY=4, WAKECYC=3: 4 idle cycles -> STBY_O=1. A read issued then -> STBY_O falls after 3 WAKE cycles; ACK at cycle 3+1+RDLAT with correct data. Memory contents are retained.
- Reset mid-read: assert RST_I in RD -> no ACK, STBY_O=0, next read completes normally.
- NPAIRS=1: ADR_I is 16 bits and only one pair is present. Writes at 0xFFFC then read -> data matches.
